// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types, constants and sizing helper for the fetch queue
package fetch_pkg;
  localparam int N_DEF = 64;
  localparam int IW_DEF = 32;
  typedef struct packed {
    logic [N_DEF-1:0] pc;
    logic [IW_DEF-1:0] instr;
  } fetch_entry_t;
  localparam logic [IW_DEF-1:0] NOP_INSTR = '0;
  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction
endpackage

// File: rtl/fetch_queue_ram.sv
// fetch_queue_ram: DEPTH-entry storage, one sync write port and one async read port
module fetch_queue_ram
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W = $bits(fetch_entry_t),
  localparam int PW = ptr_w(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [PW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [PW-1:0] raddr,
  output logic [W-1:0]  rdata
);
  logic [W-1:0] mem [DEPTH];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/fetch_queue.sv
// fetch_queue: IF/ID decoupling FIFO with flush, back-pressure and saturating stall statistic
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int N = 64,
  parameter int IW = 32,
  parameter int DEPTH = 4,
  parameter int CW = 32,
  localparam int PW = ptr_w(DEPTH),
  localparam int CNW = $clog2(DEPTH + 1)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           in_valid,
  input  logic [N-1:0]   in_pc,
  input  logic [IW-1:0]  in_instr,
  output logic           in_ready,
  input  logic           stall,
  input  logic           flush,
  output logic           out_valid,
  output logic [N-1:0]   out_pc,
  output logic [IW-1:0]  out_instr,
  output logic [CNW-1:0] count,
  output logic           full,
  output logic           empty,
  output logic [CW-1:0]  stall_cnt
);
  typedef struct packed {
    logic [N-1:0] pc;
    logic [IW-1:0] instr;
  } entry_t;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic push, pop;
  entry_t head;
  assign empty = count == '0;
  assign full = count == CNW'(DEPTH);
  assign out_valid = ~empty;
  assign in_ready = ~full | (out_valid & ~stall);
  assign push = in_valid & in_ready & ~flush;
  assign pop = out_valid & ~stall & ~flush;
  assign out_pc = out_valid ? head.pc : '0;
  assign out_instr = out_valid ? head.instr : IW'(NOP_INSTR);
  fetch_queue_ram #(.DEPTH(DEPTH), .W($bits(entry_t))) u_ram (
    .clk  (clk),
    .we   (push),
    .waddr(wr_ptr),
    .wdata({in_pc, in_instr}),
    .raddr(rd_ptr),
    .rdata(head)
  );
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      count <= (push && !pop) ? count + CNW'(1) : (pop && !push) ? count - CNW'(1) : count;
    end
  // statistic survives flush; only reset clears it
  always_ff @(posedge clk or negedge reset)
    if (!reset) stall_cnt <= '0;
    else if (out_valid && stall && !flush && !(&stall_cnt)) stall_cnt <= stall_cnt + CW'(1);
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed vector table plus hand sequences for stall, flush, saturation and reset
module tb_fetch_queue;
  localparam int N = 64, IW = 32, DEPTH = 4, CW = 32;
  logic clk = 0, reset = 0, in_valid = 0, stall = 0, flush = 0;
  logic [N-1:0] in_pc = '0;
  logic [IW-1:0] in_instr = '0;
  logic in_ready, out_valid, full, empty, in_ready_b, out_valid_b, full_b, empty_b;
  logic [N-1:0] out_pc, out_pc_b;
  logic [IW-1:0] out_instr, out_instr_b;
  logic [2:0] count, count_b;
  logic [CW-1:0] stall_cnt;
  logic [1:0] stall_cnt_b;
  int checks = 0, errors = 0;

  fetch_queue #(.N(N), .IW(IW), .DEPTH(DEPTH), .CW(CW)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_pc(in_pc), .in_instr(in_instr),
    .in_ready(in_ready), .stall(stall), .flush(flush), .out_valid(out_valid), .out_pc(out_pc),
    .out_instr(out_instr), .count(count), .full(full), .empty(empty), .stall_cnt(stall_cnt)
  );
  fetch_queue #(.N(N), .IW(IW), .DEPTH(DEPTH), .CW(2)) dut_b (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_pc(in_pc), .in_instr(in_instr),
    .in_ready(in_ready_b), .stall(stall), .flush(flush), .out_valid(out_valid_b), .out_pc(out_pc_b),
    .out_instr(out_instr_b), .count(count_b), .full(full_b), .empty(empty_b), .stall_cnt(stall_cnt_b)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic iv;
    logic [N-1:0] pc;
    logic [IW-1:0] ins;
    logic st;
    logic ov;
    logic [N-1:0] epc;
    logic [IW-1:0] eins;
    logic [2:0] cnt;
    logic efull;
    logic rdy;
    logic [CW-1:0] sc;
  } vec_t;

  vec_t tv [20];

  function automatic vec_t mk(logic iv, logic [N-1:0] pc, logic [IW-1:0] ins, logic st, logic ov,
                              logic [N-1:0] epc, logic [IW-1:0] eins, logic [2:0] cnt,
                              logic efull, logic rdy, logic [CW-1:0] sc);
    vec_t v;
    v.iv = iv; v.pc = pc; v.ins = ins; v.st = st; v.ov = ov; v.epc = epc; v.eins = eins;
    v.cnt = cnt; v.efull = efull; v.rdy = rdy; v.sc = sc;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic iv, input logic [N-1:0] pc, input logic [IW-1:0] ins,
                       input logic st, input logic fl);
    @(negedge clk);
    in_valid = iv; in_pc = pc; in_instr = ins; stall = st; flush = fl;
    #1;
  endtask

  task automatic chk_empty_state(input string nm);
    chk({nm, "_ov"}, 64'(out_valid), 64'd0);
    chk({nm, "_instr"}, 64'(out_instr), 64'd0);
    chk({nm, "_pc"}, out_pc, 64'd0);
    chk({nm, "_empty"}, 64'(empty), 64'd1);
    chk({nm, "_count"}, 64'(count), 64'd0);
    chk({nm, "_rdy"}, 64'(in_ready), 64'd1);
    chk({nm, "_full"}, 64'(full), 64'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    in_valid = 0; stall = 0; flush = 0;
    reset = 0;
    #2;
    reset = 1;
  endtask

  initial begin
    // fill under stall, drain, refill, full push+pop, drain
    tv[0]  = mk(1, 64'h0,   32'hF8000001, 1, 0, 64'h0,   32'h0,        3'd0, 0, 1, 0);
    tv[1]  = mk(1, 64'h4,   32'hF8000002, 1, 1, 64'h0,   32'hF8000001, 3'd1, 0, 1, 0);
    tv[2]  = mk(1, 64'h8,   32'hF8000003, 1, 1, 64'h0,   32'hF8000001, 3'd2, 0, 1, 1);
    tv[3]  = mk(1, 64'hC,   32'hF8000004, 1, 1, 64'h0,   32'hF8000001, 3'd3, 0, 1, 2);
    tv[4]  = mk(1, 64'h10,  32'hF8000005, 1, 1, 64'h0,   32'hF8000001, 3'd4, 1, 0, 3);
    tv[5]  = mk(0, 64'h0,   32'h0,        0, 1, 64'h0,   32'hF8000001, 3'd4, 1, 1, 4);
    tv[6]  = mk(0, 64'h0,   32'h0,        0, 1, 64'h4,   32'hF8000002, 3'd3, 0, 1, 4);
    tv[7]  = mk(0, 64'h0,   32'h0,        0, 1, 64'h8,   32'hF8000003, 3'd2, 0, 1, 4);
    tv[8]  = mk(0, 64'h0,   32'h0,        0, 1, 64'hC,   32'hF8000004, 3'd1, 0, 1, 4);
    tv[9]  = mk(0, 64'h0,   32'h0,        0, 0, 64'h0,   32'h0,        3'd0, 0, 1, 4);
    tv[10] = mk(1, 64'h100, 32'hA1,       1, 0, 64'h0,   32'h0,        3'd0, 0, 1, 4);
    tv[11] = mk(1, 64'h104, 32'hA2,       1, 1, 64'h100, 32'hA1,       3'd1, 0, 1, 4);
    tv[12] = mk(1, 64'h108, 32'hA3,       1, 1, 64'h100, 32'hA1,       3'd2, 0, 1, 5);
    tv[13] = mk(1, 64'h10C, 32'hA4,       1, 1, 64'h100, 32'hA1,       3'd3, 0, 1, 6);
    tv[14] = mk(1, 64'h10,  32'hF8000005, 0, 1, 64'h100, 32'hA1,       3'd4, 1, 1, 7);
    tv[15] = mk(0, 64'h0,   32'h0,        0, 1, 64'h104, 32'hA2,       3'd4, 1, 1, 7);
    tv[16] = mk(0, 64'h0,   32'h0,        0, 1, 64'h108, 32'hA3,       3'd3, 0, 1, 7);
    tv[17] = mk(0, 64'h0,   32'h0,        0, 1, 64'h10C, 32'hA4,       3'd2, 0, 1, 7);
    tv[18] = mk(0, 64'h0,   32'h0,        0, 1, 64'h10,  32'hF8000005, 3'd1, 0, 1, 7);
    tv[19] = mk(0, 64'h0,   32'h0,        0, 0, 64'h0,   32'h0,        3'd0, 0, 1, 7);

    #1;
    chk_empty_state("in_reset");
    @(negedge clk);
    reset = 1;
    #1;
    chk_empty_state("after_reset");

    for (int i = 0; i < 20; i++) begin
      drive(tv[i].iv, tv[i].pc, tv[i].ins, tv[i].st, 0);
      chk($sformatf("v%0d_ov", i), 64'(out_valid), 64'(tv[i].ov));
      chk($sformatf("v%0d_pc", i), out_pc, tv[i].epc);
      chk($sformatf("v%0d_instr", i), 64'(out_instr), 64'(tv[i].eins));
      chk($sformatf("v%0d_count", i), 64'(count), 64'(tv[i].cnt));
      chk($sformatf("v%0d_full", i), 64'(full), 64'(tv[i].efull));
      chk($sformatf("v%0d_empty", i), 64'(empty), 64'(tv[i].cnt == 3'd0));
      chk($sformatf("v%0d_rdy", i), 64'(in_ready), 64'(tv[i].rdy));
      chk($sformatf("v%0d_sc", i), 64'(stall_cnt), 64'(tv[i].sc));
    end

    // two entries held under a 3-cycle stall
    do_reset();
    drive(1, 64'h20, 32'hB0, 0, 0);
    drive(1, 64'h24, 32'hB1, 1, 0);
    drive(0, 64'h0, 32'h0, 1, 0);
    drive(0, 64'h0, 32'h0, 1, 0);
    drive(1, 64'h28, 32'hB2, 1, 0);
    chk("stall_head_pc", out_pc, 64'h20);
    chk("stall_count", 64'(count), 64'd2);
    chk("stall_cnt3", 64'(stall_cnt), 64'd3);
    // third entry queued; flush discards it and the concurrent offer
    drive(1, 64'h40, 32'hC0, 1, 1);
    chk("pre_flush_count", 64'(count), 64'd3);
    chk("pre_flush_sc", 64'(stall_cnt), 64'd4);
    drive(1, 64'h80, 32'hC1, 0, 0);
    chk("flush_count", 64'(count), 64'd0);
    chk("flush_ov", 64'(out_valid), 64'd0);
    chk("flush_keeps_sc", 64'(stall_cnt), 64'd4);
    drive(0, 64'h0, 32'h0, 1, 0);
    chk("post_flush_head", out_pc, 64'h80);
    chk("post_flush_instr", 64'(out_instr), 64'hC1);
    chk("post_flush_count", 64'(count), 64'd1);

    // saturation of the narrow counter, then asynchronous reset mid-burst
    do_reset();
    drive(1, 64'h60, 32'hD0, 0, 0);
    for (int k = 1; k <= 5; k++) begin
      drive(0, 64'h0, 32'h0, 1, 0);
      chk($sformatf("sat_b_%0d", k), 64'(stall_cnt_b), 64'(k - 1 > 3 ? 3 : k - 1));
    end
    drive(0, 64'h0, 32'h0, 1, 0);
    chk("sat_b_final", 64'(stall_cnt_b), 64'd3);
    chk("sat_a_final", 64'(stall_cnt), 64'd5);
    chk("sat_head_pc", out_pc_b, 64'h60);
    @(posedge clk);
    #3;
    reset = 0;
    #1;
    chk("mid_rst_count", 64'(count_b), 64'd0);
    chk("mid_rst_ov", 64'(out_valid_b), 64'd0);
    chk("mid_rst_sc_b", 64'(stall_cnt_b), 64'd0);
    chk("mid_rst_sc_a", 64'(stall_cnt), 64'd0);
    chk_empty_state("mid_rst");
    @(negedge clk);
    reset = 1;
    stall = 0;
    #1;
    chk_empty_state("final");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
